// File: rtl/pe_config_sequencer_if.sv
// Bundles the job-descriptor handshake and the register-bus initiator signals.
// The sequencer uses the master modport and the job source / register block use the slave modport.

// A descriptor transfers on any cycle where cmd_valid && cmd_ready; reg_write is a
// one-cycle command with no back-pressure and reg_rdata answers reg_addr in the same cycle.
interface pe_config_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_kw;
    logic [3:0]  cmd_kh;
    logic [7:0]  cmd_iw;
    logic [7:0]  cmd_ih;
    logic [3:0]  cmd_stride;
    logic [3:0]  cmd_pad;
    logic        reg_write;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    modport master (
        input  cmd_valid, cmd_kw, cmd_kh, cmd_iw, cmd_ih, cmd_stride, cmd_pad, reg_rdata,
        output cmd_ready, reg_write, reg_addr, reg_wdata
    );

    modport slave (
        output cmd_valid, cmd_kw, cmd_kh, cmd_iw, cmd_ih, cmd_stride, cmd_pad, reg_rdata,
        input  cmd_ready, reg_write, reg_addr, reg_wdata
    );
endinterface

// File: rtl/pe_config_sequencer.sv
// Validates one convolution job, derives output dimensions with a restoring divider,
// programs the PE config registers, starts the PE and polls its status until done or timeout.
module pe_config_sequencer #(
    parameter int TIMEOUT_W = 16,
    parameter int TIMEOUT   = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pe_config_sequencer_if.master bus,
    output logic                  busy,
    output logic                  job_done,
    output logic [1:0]            job_status,
    output logic [7:0]            out_w,
    output logic [7:0]            out_h
);
    typedef enum logic [3:0] {
        IDLE, CHECK, DIV, WR_KDIM, WR_IDIM, WR_PARAM, WR_ODIM, WR_CTRL,
        POLL_LOW, POLL_HIGH, FINISH
    } state_t;

    localparam logic [TIMEOUT_W:0] TIMEOUT_LIM = (TIMEOUT_W + 1)'(TIMEOUT);

    state_t               state;
    logic [3:0]           kw, kh, stride, pad;
    logic [7:0]           iw, ih;
    logic [8:0]           nw_sh, nh_sh, qw, qh;
    logic [3:0]           rw, rh, div_cnt;
    logic [TIMEOUT_W-1:0] tcnt;

    logic [9:0]           span_w, span_h, nw_full, nh_full, ow_full, oh_full;
    logic [4:0]           step_w, step_h;
    logic [8:0]           qw_nx, qh_nx;
    logic                 bad_param, range_err, done_bit;
    logic [TIMEOUT_W:0]   tcnt_nx;
    logic                 unused_bits;

    // One restoring step: returns {quotient bit, new remainder}; remainder stays below d.
    function automatic logic [4:0] div_step(input logic [3:0] r, input logic b, input logic [3:0] d);
        logic [4:0] t;
        logic [3:0] diff;
        t    = {r, b};
        diff = t[3:0] - d;
        if (t >= {1'b0, d}) return {1'b1, diff};
        return {1'b0, t[3:0]};
    endfunction

    always_comb begin
        span_w    = {2'b0, iw} + {5'b0, pad, 1'b0};
        span_h    = {2'b0, ih} + {5'b0, pad, 1'b0};
        nw_full   = span_w - {6'b0, kw};
        nh_full   = span_h - {6'b0, kh};
        bad_param = (stride == 4'd0) || (kw == 4'd0) || (kh == 4'd0) ||
                    ({6'b0, kw} > span_w) || ({6'b0, kh} > span_h);
        step_w    = div_step(rw, nw_sh[8], stride);
        step_h    = div_step(rh, nh_sh[8], stride);
        qw_nx     = {qw[7:0], step_w[4]};
        qh_nx     = {qh[7:0], step_h[4]};
        ow_full   = {1'b0, qw_nx} + 10'd1;
        oh_full   = {1'b0, qh_nx} + 10'd1;
        range_err = (ow_full > 10'd255) || (oh_full > 10'd255);
        tcnt_nx   = {1'b0, tcnt} + (TIMEOUT_W + 1)'(1);
        done_bit  = bus.reg_rdata[0];
    end

    assign unused_bits   = ^{bus.reg_rdata[31:1], qw[8], qh[8], nw_full[9], nh_full[9]};
    assign bus.cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.reg_write <= 1'b0;
            bus.reg_addr  <= 4'd0;
            bus.reg_wdata <= 32'd0;
            busy          <= 1'b0;
            job_done      <= 1'b0;
            job_status    <= 2'd0;
            out_w         <= 8'd0;
            out_h         <= 8'd0;
            tcnt          <= '0;
            kw <= 4'd0; kh <= 4'd0; stride <= 4'd0; pad <= 4'd0;
            iw <= 8'd0; ih <= 8'd0;
            nw_sh <= 9'd0; nh_sh <= 9'd0; qw <= 9'd0; qh <= 9'd0;
            rw <= 4'd0; rh <= 4'd0; div_cnt <= 4'd0;
        end else begin
            bus.reg_write <= 1'b0;
            bus.reg_addr  <= 4'd0;
            bus.reg_wdata <= 32'd0;
            job_done      <= 1'b0;
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    kw <= bus.cmd_kw; kh <= bus.cmd_kh;
                    iw <= bus.cmd_iw; ih <= bus.cmd_ih;
                    stride <= bus.cmd_stride; pad <= bus.cmd_pad;
                    busy  <= 1'b1;
                    state <= CHECK;
                end
                CHECK: if (bad_param) begin
                    job_done   <= 1'b1;
                    job_status <= 2'd1;
                    state      <= FINISH;
                end else begin
                    nw_sh <= nw_full[8:0]; nh_sh <= nh_full[8:0];
                    qw <= 9'd0; qh <= 9'd0; rw <= 4'd0; rh <= 4'd0;
                    div_cnt <= 4'd0;
                    state   <= DIV;
                end
                DIV: begin
                    nw_sh <= {nw_sh[7:0], 1'b0}; nh_sh <= {nh_sh[7:0], 1'b0};
                    rw <= step_w[3:0]; rh <= step_h[3:0];
                    qw <= qw_nx; qh <= qh_nx;
                    div_cnt <= div_cnt + 4'd1;
                    // Ninth step has just produced the last quotient bit.
                    if (div_cnt == 4'd8) begin
                        if (range_err) begin
                            job_done   <= 1'b1;
                            job_status <= 2'd2;
                            state      <= FINISH;
                        end else begin
                            out_w         <= ow_full[7:0];
                            out_h         <= oh_full[7:0];
                            bus.reg_write <= 1'b1;
                            bus.reg_addr  <= 4'd2;
                            bus.reg_wdata <= {20'b0, kh, 4'b0, kw};
                            state         <= WR_KDIM;
                        end
                    end
                end
                WR_KDIM: begin
                    bus.reg_write <= 1'b1;
                    bus.reg_addr  <= 4'd3;
                    bus.reg_wdata <= {16'b0, ih, iw};
                    state         <= WR_IDIM;
                end
                WR_IDIM: begin
                    bus.reg_write <= 1'b1;
                    bus.reg_addr  <= 4'd4;
                    bus.reg_wdata <= {24'b0, pad, stride};
                    state         <= WR_PARAM;
                end
                WR_PARAM: begin
                    bus.reg_write <= 1'b1;
                    bus.reg_addr  <= 4'd5;
                    bus.reg_wdata <= {16'b0, out_h, out_w};
                    state         <= WR_ODIM;
                end
                WR_ODIM: begin
                    bus.reg_write <= 1'b1;
                    bus.reg_addr  <= 4'd0;
                    bus.reg_wdata <= 32'h1;
                    state         <= WR_CTRL;
                end
                WR_CTRL: begin
                    bus.reg_addr <= 4'd1;
                    tcnt         <= '0;
                    state        <= POLL_LOW;
                end
                // POLL_LOW only passes once done drops, so a stale done cannot complete the job.
                POLL_LOW: begin
                    bus.reg_addr <= 4'd1;
                    tcnt         <= tcnt_nx[TIMEOUT_W-1:0];
                    if (tcnt_nx == TIMEOUT_LIM) begin
                        job_done   <= 1'b1;
                        job_status <= 2'd3;
                        state      <= FINISH;
                    end else if (!done_bit) begin
                        state <= POLL_HIGH;
                    end
                end
                POLL_HIGH: begin
                    bus.reg_addr <= 4'd1;
                    tcnt         <= tcnt_nx[TIMEOUT_W-1:0];
                    if (done_bit) begin
                        job_done   <= 1'b1;
                        job_status <= 2'd0;
                        state      <= FINISH;
                    end else if (tcnt_nx == TIMEOUT_LIM) begin
                        job_done   <= 1'b1;
                        job_status <= 2'd3;
                        state      <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_config_sequencer.sv
// Directed bench for pe_config_sequencer: register-block model with a scripted done bit,
// write/job_done monitor, and hand-computed expectations per job.
module tb_pe_config_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy, job_done;
    logic [1:0] job_status;
    logic [7:0] out_w, out_h;

    always #5 clk = ~clk;

    pe_config_sequencer_if bus ();

    pe_config_sequencer #(.TIMEOUT_W(16), .TIMEOUT(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .job_done   (job_done),
        .job_status (job_status),
        .out_w      (out_w),
        .out_h      (out_h)
    );

    // Register block model; done_mode 0: done rises 5 cycles after ctrl write, 1: stuck low, 2: stuck high.
    logic [31:0] regs [0:15];
    int          done_mode = 0;
    int          since = 0;
    logic        started = 1'b0;
    logic        done_bit;

    always @(posedge clk) begin
        if (bus.reg_write) regs[bus.reg_addr] <= bus.reg_wdata;
        if (bus.cmd_valid && bus.cmd_ready) started <= 1'b0;
        else if (bus.reg_write && bus.reg_addr == 4'd0) begin
            started <= 1'b1;
            since   <= 0;
        end else if (started) since <= since + 1;
    end

    assign done_bit = (done_mode == 1) ? 1'b0 : (done_mode == 2) ? 1'b1 : (started && since >= 5);
    assign bus.reg_rdata = (bus.reg_addr == 4'd1) ? {31'b0, done_bit} : regs[bus.reg_addr];

    // Cycle counter and monitor; spec cycle numbers are cyc - acc + 1.
    int          cyc = 0;
    int          acc = 0;
    logic [35:0] wr_q[$];
    int          wr_cyc_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [1:0]  done_st = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.reg_write) begin
            wr_q.push_back({bus.reg_addr, bus.reg_wdata});
            wr_cyc_q.push_back(cyc - acc + 1);
        end
        if (job_done) begin
            done_cnt++;
            done_cyc = cyc - acc + 1;
            done_st  = job_status;
        end
    end

    // Scoreboard.
    logic [35:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          wr_base = 0;
    int          done_base = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_job(input logic [3:0] kw, input logic [3:0] kh, input logic [7:0] iw,
                             input logic [7:0] ih, input logic [3:0] stride, input logic [3:0] pad);
        @(negedge clk);
        bus.cmd_kw = kw; bus.cmd_kh = kh; bus.cmd_iw = iw; bus.cmd_ih = ih;
        bus.cmd_stride = stride; bus.cmd_pad = pad;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        acc       = cyc;
        wr_base   = wr_q.size();
        done_base = done_cnt;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (done_cnt == done_base && i < 300) begin
            @(negedge clk);
            #1;
            i++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt - done_base), 32'd1);
    endtask

    task automatic check_writes(input string tag, input int first_cyc);
        int n;
        n = wr_q.size() - wr_base;
        check({tag, "_wr_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check({tag, "_wr_addr"}, 32'(wr_q[wr_base + i][35:32]), 32'(exp_q[i][35:32]));
            check({tag, "_wr_data"}, wr_q[wr_base + i][31:0], exp_q[i][31:0]);
            check({tag, "_wr_cycle"}, 32'(wr_cyc_q[wr_base + i]), 32'(first_cyc + i));
        end
        exp_q.delete();
    endtask

    task automatic push_job1_writes();
        exp_q.push_back({4'd2, 32'h303});
        exp_q.push_back({4'd3, 32'h0808});
        exp_q.push_back({4'd4, 32'h01});
        exp_q.push_back({4'd5, 32'h0606});
        exp_q.push_back({4'd0, 32'h1});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'd0;
        bus.cmd_valid = 1'b0;
        bus.cmd_kw = 4'd0; bus.cmd_kh = 4'd0; bus.cmd_iw = 8'd0; bus.cmd_ih = 8'd0;
        bus.cmd_stride = 4'd0; bus.cmd_pad = 4'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_reg_write", 32'(bus.reg_write), 32'd0);
        check("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        check("rst_reg_wdata", bus.reg_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_job_done", 32'(job_done), 32'd0);
        check("rst_job_status", 32'(job_status), 32'd0);
        check("rst_out", 32'({out_h, out_w}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Job 1: 8x8 input, 3x3 kernel, stride 1.
        done_mode = 0;
        start_job(4'd3, 4'd3, 8'd8, 8'd8, 4'd1, 4'd0);
        check("j1_busy", 32'(busy), 32'd1);
        check("j1_ready_low", 32'(bus.cmd_ready), 32'd0);
        wait_done("j1");
        check("j1_status", 32'(done_st), 32'd0);
        check("j1_done_cycle", 32'(done_cyc), 32'd22);
        check("j1_out_w", 32'(out_w), 32'd6);
        check("j1_out_h", 32'(out_h), 32'd6);
        push_job1_writes();
        check_writes("j1", 11);
        @(negedge clk);
        check("j1_ready_after", 32'(bus.cmd_ready), 32'd1);
        check("j1_busy_after", 32'(busy), 32'd0);

        // Job 2: stride 2, pad 1; cmd_valid held with other fields mid-job must be ignored.
        start_job(4'd5, 4'd3, 8'd28, 8'd20, 4'd2, 4'd1);
        bus.cmd_kw = 4'd1; bus.cmd_kh = 4'd1; bus.cmd_iw = 8'd99; bus.cmd_ih = 8'd77;
        bus.cmd_stride = 4'd3; bus.cmd_pad = 4'd0;
        bus.cmd_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.cmd_valid = 1'b0;
        wait_done("j2");
        check("j2_status", 32'(done_st), 32'd0);
        check("j2_out_w", 32'(out_w), 32'd13);
        check("j2_out_h", 32'(out_h), 32'd10);
        exp_q.push_back({4'd2, 32'h305});
        exp_q.push_back({4'd3, 32'h141C});
        exp_q.push_back({4'd4, 32'h12});
        exp_q.push_back({4'd5, 32'h0A0D});
        exp_q.push_back({4'd0, 32'h1});
        check_writes("j2", 11);

        // Job 3: stride 0 is rejected in CHECK.
        start_job(4'd3, 4'd3, 8'd8, 8'd8, 4'd0, 4'd0);
        wait_done("j3");
        check("j3_status", 32'(done_st), 32'd1);
        check("j3_done_cycle", 32'(done_cyc), 32'd2);
        check("j3_ready_c2", 32'(bus.cmd_ready), 32'd0);
        check_writes("j3", 0);
        @(negedge clk);
        check("j3_ready_c3", 32'(bus.cmd_ready), 32'd1);

        // Job 4a: kernel wider than padded input.
        start_job(4'd9, 4'd3, 8'd4, 8'd8, 4'd1, 4'd2);
        wait_done("j4a");
        check("j4a_status", 32'(done_st), 32'd1);
        check("j4a_done_cycle", 32'(done_cyc), 32'd2);
        check_writes("j4a", 0);

        // Job 4b: 255+4-1+1 = 259 output columns overflows.
        start_job(4'd1, 4'd1, 8'd255, 8'd255, 4'd1, 4'd2);
        wait_done("j4b");
        check("j4b_status", 32'(done_st), 32'd2);
        check("j4b_done_cycle", 32'(done_cyc), 32'd11);
        check_writes("j4b", 0);

        // Job 5a: done stuck low -> timeout 20 cycles after POLL_LOW entry at cycle 16.
        done_mode = 1;
        start_job(4'd3, 4'd3, 8'd8, 8'd8, 4'd1, 4'd0);
        wait_done("j5a");
        check("j5a_status", 32'(done_st), 32'd3);
        check("j5a_done_cycle", 32'(done_cyc), 32'd36);
        push_job1_writes();
        check_writes("j5a", 11);

        // Job 5b: stale done stuck high must never be taken as OK.
        done_mode = 2;
        start_job(4'd3, 4'd3, 8'd8, 8'd8, 4'd1, 4'd0);
        wait_done("j5b");
        check("j5b_status", 32'(done_st), 32'd3);
        check("j5b_done_cycle", 32'(done_cyc), 32'd36);

        // Job 6: reset during WR_PARAM, then a clean rerun of job 1.
        done_mode = 0;
        start_job(4'd3, 4'd3, 8'd8, 8'd8, 4'd1, 4'd0);
        for (int i = 0; i < 40 && (cyc - acc + 1) < 13; i++) @(negedge clk);
        check("j6_in_wr_param", 32'({bus.reg_write, bus.reg_addr}), 32'h14);
        #2;
        rst_n = 1'b0;
        #1;
        check("j6_rst_reg_write", 32'(bus.reg_write), 32'd0);
        check("j6_rst_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("j6_no_job_done", 32'(done_cnt - done_base), 32'd0);
        check("j6_writes_before_rst", 32'(wr_q.size() - wr_base), 32'd3);
        rst_n = 1'b1;
        start_job(4'd3, 4'd3, 8'd8, 8'd8, 4'd1, 4'd0);
        wait_done("j6");
        check("j6_status", 32'(done_st), 32'd0);
        check("j6_done_cycle", 32'(done_cyc), 32'd22);
        push_job1_writes();
        check_writes("j6", 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
